// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control unit: opcodes, ALU function
// codes, writeback/PC source selects and the sequencer state type.
package riscv_ctrl_pkg;

  localparam int unsigned ALU_OP_W = 4;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [ALU_OP_W-1:0] ALU_ADD   = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB   = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_AND   = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OR    = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_XOR   = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_SLL   = 4'd5;
  localparam logic [ALU_OP_W-1:0] ALU_SRL   = 4'd6;
  localparam logic [ALU_OP_W-1:0] ALU_SRA   = 4'd7;
  localparam logic [ALU_OP_W-1:0] ALU_SLT   = 4'd8;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU  = 4'd9;
  localparam logic [ALU_OP_W-1:0] ALU_PASSB = 4'd10;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [1:0] PC_SRC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_SRC_TARGET = 2'd1;

  typedef enum logic [2:0] {
    ST_RESET,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEM,
    ST_WRITEBACK,
    ST_TRAP
  } state_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Control-unit bundle: decoded instruction fields and status in, datapath enables and
// mux selects out.  master = control unit, slave = datapath.
interface multicycle_control_if #(
  parameter int unsigned ALU_OP_W = riscv_ctrl_pkg::ALU_OP_W
);
  logic [6:0]          opcode;
  logic [2:0]          funct3;
  logic [6:0]          funct7;
  logic                mem_ready;
  logic                branch_taken;
  logic                mem_req;
  logic                mem_we;
  logic                mem_sel_data;
  logic                ir_we;
  logic                pc_we;
  logic [1:0]          pc_src;
  logic                reg_we;
  logic [1:0]          wb_sel;
  logic                alu_src_b;
  logic [ALU_OP_W-1:0] alu_op;
  logic                illegal;

  modport master (
    input  opcode, funct3, funct7, mem_ready, branch_taken,
    output mem_req, mem_we, mem_sel_data, ir_we, pc_we, pc_src,
           reg_we, wb_sel, alu_src_b, alu_op, illegal
  );

  modport slave (
    output opcode, funct3, funct7, mem_ready, branch_taken,
    input  mem_req, mem_we, mem_sel_data, ir_we, pc_we, pc_src,
           reg_we, wb_sel, alu_src_b, alu_op, illegal
  );
endinterface

// File: rtl/alu_op_decode.sv
// Maps decoded instruction fields to an ALU function code; shared by the ALU-op and
// branch-compare paths of the control unit.
module alu_op_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  output logic [ALU_OP_W-1:0] alu_op
);

  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  always_comb begin
    alu_op = ALU_ADD;
    case (opcode)
      OP_RTYPE, OP_IALU: begin
        case (funct3)
          // immediate forms have no SUB: funct7 there is part of the immediate
          3'b000: alu_op = (opcode == OP_RTYPE && funct7[5]) ? ALU_SUB : ALU_ADD;
          3'b001: alu_op = ALU_SLL;
          3'b010: alu_op = ALU_SLT;
          3'b011: alu_op = ALU_SLTU;
          3'b100: alu_op = ALU_XOR;
          3'b101: alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
          3'b110: alu_op = ALU_OR;
          3'b111: alu_op = ALU_AND;
        endcase
      end
      OP_BRANCH: begin
        case (funct3[2:1])
          2'b10:   alu_op = ALU_SLT;
          2'b11:   alu_op = ALU_SLTU;
          default: alu_op = ALU_SUB;
        endcase
      end
      OP_LUI:  alu_op = ALU_PASSB;
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I sequencer: FETCH, DECODE, EXECUTE, MEM, WRITEBACK with a sticky
// TRAP for unsupported opcodes.  Outputs decode from the state register and fields.
module multicycle_control #(
  parameter int unsigned ALU_OP_W = riscv_ctrl_pkg::ALU_OP_W
) (
  input  logic                 clock,
  input  logic                 rst_n,
  multicycle_control_if.master bus
);
  import riscv_ctrl_pkg::*;

  state_t                               state;
  logic [riscv_ctrl_pkg::ALU_OP_W-1:0] dec_op;

  alu_op_decode u_alu_op_decode (
    .opcode (bus.opcode),
    .funct3 (bus.funct3),
    .funct7 (bus.funct7),
    .alu_op (dec_op)
  );

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RESET;
    end else begin
      case (state)
        ST_RESET:  state <= ST_FETCH;
        ST_FETCH:  if (bus.mem_ready) state <= ST_DECODE;
        ST_DECODE: state <= ST_EXECUTE;
        ST_EXECUTE: begin
          case (bus.opcode)
            OP_RTYPE, OP_IALU, OP_JAL, OP_LUI: state <= ST_WRITEBACK;
            OP_LOAD, OP_STORE:                 state <= ST_MEM;
            OP_BRANCH:                         state <= ST_FETCH;
            default:                           state <= ST_TRAP;
          endcase
        end
        ST_MEM: begin
          if (bus.mem_ready) state <= (bus.opcode == OP_LOAD) ? ST_WRITEBACK : ST_FETCH;
        end
        ST_WRITEBACK: state <= ST_FETCH;
        ST_TRAP:      state <= ST_TRAP;
        default:      state <= ST_RESET;
      endcase
    end
  end

  always_comb begin
    bus.mem_req      = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_sel_data = 1'b0;
    bus.ir_we        = 1'b0;
    bus.pc_we        = 1'b0;
    bus.pc_src       = PC_SRC_PLUS4;
    bus.reg_we       = 1'b0;
    bus.wb_sel       = WB_ALU;
    bus.alu_src_b    = 1'b0;
    bus.alu_op       = '0;
    bus.illegal      = 1'b0;
    case (state)
      ST_FETCH: begin
        bus.mem_req = 1'b1;
        bus.ir_we   = bus.mem_ready;
        bus.pc_we   = bus.mem_ready;
      end
      ST_EXECUTE: begin
        bus.alu_op = ALU_OP_W'(dec_op);
        case (bus.opcode)
          OP_IALU, OP_LOAD, OP_STORE, OP_LUI: bus.alu_src_b = 1'b1;
          OP_BRANCH: begin
            bus.pc_we  = bus.branch_taken;
            bus.pc_src = PC_SRC_TARGET;
          end
          OP_JAL: begin
            bus.pc_we  = 1'b1;
            bus.pc_src = PC_SRC_TARGET;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        bus.mem_req      = 1'b1;
        bus.mem_sel_data = 1'b1;
        bus.mem_we       = (bus.opcode == OP_STORE);
      end
      ST_WRITEBACK: begin
        bus.reg_we = 1'b1;
        if (bus.opcode == OP_LOAD)     bus.wb_sel = WB_MEM;
        else if (bus.opcode == OP_JAL) bus.wb_sel = WB_PC4;
      end
      ST_TRAP: bus.illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-scenario tasks compare the packed output
// vector against hand-derived values one cycle at a time.
module tb_multicycle_control;

  logic        clock = 1'b0;
  logic        rst_n;
  int unsigned n_run  = 0;
  int unsigned n_fail = 0;

  always #5 clock = ~clock;

  multicycle_control_if #(.ALU_OP_W(4)) bus ();

  multicycle_control #(.ALU_OP_W(4)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // packed layout: req we sel ir pcw pcs[2] rw wbs[2] srcb alu[4] ill
  function automatic logic [15:0] outs();
    return {bus.mem_req, bus.mem_we, bus.mem_sel_data, bus.ir_we, bus.pc_we, bus.pc_src,
            bus.reg_we, bus.wb_sel, bus.alu_src_b, bus.alu_op, bus.illegal};
  endfunction

  function automatic logic [15:0] o(input int req, input int we, input int sel, input int ir,
                                    input int pcw, input int pcs, input int rw, input int wbs,
                                    input int srcb, input int alu, input int ill);
    return {req[0], we[0], sel[0], ir[0], pcw[0], 2'(pcs), rw[0], 2'(wbs), srcb[0], 4'(alu), ill[0]};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    bus.opcode = op;
    bus.funct3 = f3;
    bus.funct7 = f7;
  endtask

  task automatic test_reset();
    logic [15:0] e;
    rst_n = 1'b0;
    bus.mem_ready = 1'b0;
    bus.branch_taken = 1'b0;
    set_instr(7'd0, 3'd0, 7'd0);
    tick(); tick();
    e = '0;
    n_run++; if (outs() !== e) begin n_fail++; $display("FAIL reset_idle: got %h expected %h", outs(), e); end
    rst_n = 1'b1;
    #1;
    n_run++; if (outs() !== e) begin n_fail++; $display("FAIL reset_before_edge: got %h expected %h", outs(), e); end
    tick();
    e = o(1,0,0,0,0,0,0,0,0,0,0);
    n_run++; if (outs() !== e) begin n_fail++; $display("FAIL fetch_after_release: got %h expected %h", outs(), e); end
    tick();
    n_run++; if (outs() !== e) begin n_fail++; $display("FAIL fetch_wait_hold: got %h expected %h", outs(), e); end
    #2 rst_n = 1'b0;
    #1;
    e = '0;
    n_run++; if (outs() !== e) begin n_fail++; $display("FAIL async_reset_mid_fetch: got %h expected %h", outs(), e); end
    tick();
    rst_n = 1'b1;
    tick();
    e = o(1,0,0,0,0,0,0,0,0,0,0);
    n_run++; if (outs() !== e) begin n_fail++; $display("FAIL mem_req_one_cycle_after_release: got %h expected %h", outs(), e); end
  endtask

  task automatic test_rtype();
    logic [2:0]  f3 [4] = '{3'b000, 3'b000, 3'b101, 3'b111};
    logic [6:0]  f7 [4] = '{7'h00, 7'h20, 7'h20, 7'h00};
    int          alu [4] = '{0, 1, 7, 2};
    logic [15:0] e;
    for (int i = 0; i < 4; i++) begin
      set_instr(7'b0110011, f3[i], f7[i]);
      bus.mem_ready = 1'b1;
      #1;
      e = o(1,0,0,1,1,0,0,0,0,0,0);
      n_run++; if (outs() !== e) begin n_fail++; $display("FAIL rtype%0d_fetch: got %h expected %h", i, outs(), e); end
      tick();
      e = '0;
      n_run++; if (outs() !== e) begin n_fail++; $display("FAIL rtype%0d_decode: got %h expected %h", i, outs(), e); end
      tick();
      e = o(0,0,0,0,0,0,0,0,0,alu[i],0);
      n_run++; if (outs() !== e) begin n_fail++; $display("FAIL rtype%0d_execute: got %h expected %h", i, outs(), e); end
      tick();
      e = o(0,0,0,0,0,0,1,0,0,0,0);
      n_run++; if (outs() !== e) begin n_fail++; $display("FAIL rtype%0d_writeback: got %h expected %h", i, outs(), e); end
      tick();
    end
  endtask

  task automatic test_itype();
    logic [2:0]  f3 [4] = '{3'b101, 3'b000, 3'b101, 3'b011};
    logic [6:0]  f7 [4] = '{7'h20, 7'h20, 7'h00, 7'h7f};
    int          alu [4] = '{7, 0, 6, 9};
    logic [15:0] e;
    for (int i = 0; i < 4; i++) begin
      set_instr(7'b0010011, f3[i], f7[i]);
      tick(); tick();
      e = o(0,0,0,0,0,0,0,0,1,alu[i],0);
      n_run++; if (outs() !== e) begin n_fail++; $display("FAIL itype%0d_execute: got %h expected %h", i, outs(), e); end
      tick();
      e = o(0,0,0,0,0,0,1,0,0,0,0);
      n_run++; if (outs() !== e) begin n_fail++; $display("FAIL itype%0d_writeback: got %h expected %h", i, outs(), e); end
      tick();
    end
  endtask

  task automatic test_lui_jal();
    logic [15:0] e;
    set_instr(7'b0110111, 3'b010, 7'h11);
    tick(); tick();
    e = o(0,0,0,0,0,0,0,0,1,10,0);
    n_run++; if (outs() !== e) begin n_fail++; $display("FAIL lui_execute: got %h expected %h", outs(), e); end
    tick();
    e = o(0,0,0,0,0,0,1,0,0,0,0);
    n_run++; if (outs() !== e) begin n_fail++; $display("FAIL lui_writeback: got %h expected %h", outs(), e); end
    tick();
    set_instr(7'b1101111, 3'b000, 7'h00);
    tick(); tick();
    e = o(0,0,0,0,1,1,0,0,0,0,0);
    n_run++; if (outs() !== e) begin n_fail++; $display("FAIL jal_execute: got %h expected %h", outs(), e); end
    tick();
    e = o(0,0,0,0,0,0,1,2,0,0,0);
    n_run++; if (outs() !== e) begin n_fail++; $display("FAIL jal_writeback: got %h expected %h", outs(), e); end
    tick();
    e = o(1,0,0,1,1,0,0,0,0,0,0);
    n_run++; if (outs() !== e) begin n_fail++; $display("FAIL jal_next_fetch: got %h expected %h", outs(), e); end
  endtask

  task automatic test_load_wait();
    logic [15:0] e;
    set_instr(7'b0000011, 3'b010, 7'h00);
    tick(); tick();
    e = o(0,0,0,0,0,0,0,0,1,0,0);
    n_run++; if (outs() !== e) begin n_fail++; $display("FAIL load_execute: got %h expected %h", outs(), e); end
    bus.mem_ready = 1'b0;
    tick();
    e = o(1,0,1,0,0,0,0,0,0,0,0);
    n_run++; if (outs() !== e) begin n_fail++; $display("FAIL load_mem_wait1: got %h expected %h", outs(), e); end
    tick();
    n_run++; if (outs() !== e) begin n_fail++; $display("FAIL load_mem_wait2: got %h expected %h", outs(), e); end
    bus.mem_ready = 1'b1;
    #1;
    n_run++; if (outs() !== e) begin n_fail++; $display("FAIL load_mem_handshake: got %h expected %h", outs(), e); end
    tick();
    e = o(0,0,0,0,0,0,1,1,0,0,0);
    n_run++; if (outs() !== e) begin n_fail++; $display("FAIL load_writeback: got %h expected %h", outs(), e); end
    tick();
    e = o(1,0,0,1,1,0,0,0,0,0,0);
    n_run++; if (outs() !== e) begin n_fail++; $display("FAIL load_next_fetch: got %h expected %h", outs(), e); end
  endtask

  task automatic test_store();
    logic [15:0] e;
    set_instr(7'b0100011, 3'b010, 7'h00);
    tick(); tick();
    e = o(0,0,0,0,0,0,0,0,1,0,0);
    n_run++; if (outs() !== e) begin n_fail++; $display("FAIL store_execute: got %h expected %h", outs(), e); end
    tick();
    e = o(1,1,1,0,0,0,0,0,0,0,0);
    n_run++; if (outs() !== e) begin n_fail++; $display("FAIL store_mem: got %h expected %h", outs(), e); end
    tick();
    e = o(1,0,0,1,1,0,0,0,0,0,0);
    n_run++; if (outs() !== e) begin n_fail++; $display("FAIL store_next_fetch: got %h expected %h", outs(), e); end
  endtask

  task automatic test_branch();
    logic [2:0]  f3 [4] = '{3'b000, 3'b000, 3'b100, 3'b111};
    logic        tk [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    int          alu [4] = '{1, 1, 8, 9};
    logic [15:0] e;
    for (int i = 0; i < 4; i++) begin
      set_instr(7'b1100011, f3[i], 7'h00);
      bus.branch_taken = 1'b0;
      tick();
      bus.branch_taken = tk[i];
      tick();
      e = o(0,0,0,0,tk[i],1,0,0,0,alu[i],0);
      n_run++; if (outs() !== e) begin n_fail++; $display("FAIL branch%0d_execute: got %h expected %h", i, outs(), e); end
      tick();
      e = o(1,0,0,1,1,0,0,0,0,0,0);
      n_run++; if (outs() !== e) begin n_fail++; $display("FAIL branch%0d_next_fetch: got %h expected %h", i, outs(), e); end
    end
    bus.branch_taken = 1'b0;
  endtask

  task automatic test_trap();
    logic [15:0] e;
    set_instr(7'b1111111, 3'b000, 7'h00);
    tick(); tick();
    e = '0;
    n_run++; if (outs() !== e) begin n_fail++; $display("FAIL trap_execute: got %h expected %h", outs(), e); end
    e = o(0,0,0,0,0,0,0,0,0,0,1);
    for (int i = 0; i < 10; i++) begin
      tick();
      bus.mem_ready    = i[0];
      bus.branch_taken = ~i[0];
      #1;
      n_run++; if (outs() !== e) begin n_fail++; $display("FAIL trap_hold%0d: got %h expected %h", i, outs(), e); end
    end
    rst_n = 1'b0;
    #1;
    e = '0;
    n_run++; if (outs() !== e) begin n_fail++; $display("FAIL trap_cleared_by_reset: got %h expected %h", outs(), e); end
    bus.mem_ready = 1'b1;
    bus.branch_taken = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    e = o(1,0,0,1,1,0,0,0,0,0,0);
    n_run++; if (outs() !== e) begin n_fail++; $display("FAIL fetch_after_trap_reset: got %h expected %h", outs(), e); end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_itype();
    test_lui_jal();
    test_load_wait();
    test_store();
    test_branch();
    test_trap();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
